settings_menu_ctrl: RTL and testbench



---
 rtl/settings_pkg.sv | 52 +++++
 rtl/settings_menu_ctrl_if.sv | 13 +
 rtl/settings_btn_edge.sv | 28 ++
 rtl/settings_menu_ctrl.sv | 142 ++++++++++++++
 tb/tb_settings_menu_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/settings_pkg.sv
// Shared constants, types and geometry helpers for the settings-menu controller.
package settings_pkg;

    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] GREEN = 16'h07E0;

    localparam logic [6:0] BAND_X_LO  = 7'd20;
    localparam logic [6:0] BAND_X_HI  = 7'd69;
    localparam logic [5:0] BAND1_Y_LO = 6'd34;
    localparam logic [5:0] BAND1_Y_HI = 6'd40;
    localparam logic [5:0] BAND2_Y_LO = 6'd43;
    localparam logic [5:0] BAND2_Y_HI = 6'd49;

    localparam logic [6:0] MARK_X_LO  = 7'd16;
    localparam logic [6:0] MARK_X_HI  = 7'd18;
    localparam logic [5:0] MARK1_Y_LO = 6'd36;
    localparam logic [5:0] MARK1_Y_HI = 6'd38;
    localparam logic [5:0] MARK2_Y_LO = 6'd45;
    localparam logic [5:0] MARK2_Y_HI = 6'd47;

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_1    = 2'd1;
    localparam logic [1:0] MODE_2    = 2'd2;

    typedef logic [0:0] state_t;
    localparam state_t ST_BROWSE  = 1'b0;
    localparam state_t ST_CONFIRM = 1'b1;

    function automatic logic in_band(input logic [6:0] px, input logic [5:0] py,
                                     input logic cur);
        logic y_ok;
        if (cur) begin
            y_ok = (py >= BAND2_Y_LO) && (py <= BAND2_Y_HI);
        end else begin
            y_ok = (py >= BAND1_Y_LO) && (py <= BAND1_Y_HI);
        end
        return y_ok && (px >= BAND_X_LO) && (px <= BAND_X_HI);
    endfunction

    function automatic logic in_marker(input logic [6:0] px, input logic [5:0] py,
                                       input logic [1:0] m);
        logic y_ok;
        case (m)
            MODE_1:  y_ok = (py >= MARK1_Y_LO) && (py <= MARK1_Y_HI);
            MODE_2:  y_ok = (py >= MARK2_Y_LO) && (py <= MARK2_Y_HI);
            default: y_ok = 1'b0;
        endcase
        return y_ok && (px >= MARK_X_LO) && (px <= MARK_X_HI);
    endfunction

endpackage

// File: rtl/settings_menu_ctrl_if.sv
// Pixel bus between the OLED driver/renderer pair and the settings-menu controller.
interface settings_menu_ctrl_if;
    logic [12:0] pixel_index;
    logic [15:0] settings_data;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [15:0] oled_data;

    modport master (output pixel_index, output settings_data,
                    input x, input y, input oled_data);
    modport slave  (input pixel_index, input settings_data,
                    output x, output y, output oled_data);
endinterface

// File: rtl/settings_btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for one raw push button.
module settings_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);
    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronise the asynchronous level and keep one cycle of history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign level = sync2_r;
    assign rise  = sync2_r & ~prev_r;
endmodule

// File: rtl/settings_menu_ctrl.sv
// Settings-menu control: button FSM, pixel index to x/y, cursor highlight and mode marker.
// Optional highlight blinking is enabled by defining SETTINGS_BLINK_EN.
module settings_menu_ctrl
    import settings_pkg::*;
#(
    parameter int WIDTH      = 96,
    parameter int HEIGHT     = 64,
    parameter int BLINK_BITS = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_centre,
    settings_menu_ctrl_if.slave pix,
    output logic               cursor,
    output logic [1:0]         mode,
    output logic               mode_valid
);
    logic up_rise_s, down_rise_s, centre_rise_s;
    logic up_lvl_s, down_lvl_s, centre_lvl_s;
    logic hl_en_s;
    logic [6:0]  x_s;
    logic [5:0]  y_s;
    logic        oob_s;
    logic [15:0] pix_s;

    state_t      state_r;
    logic        cursor_r;
    logic [1:0]  mode_r;
    logic        mode_valid_r;
    logic [6:0]  x_r;
    logic [5:0]  y_r;
    logic        oob_r;
    logic [15:0] oled_r;

    settings_btn_edge u_up     (.clk(clk), .rst_n(rst_n), .btn(btn_up),
                                .level(up_lvl_s), .rise(up_rise_s));
    settings_btn_edge u_down   (.clk(clk), .rst_n(rst_n), .btn(btn_down),
                                .level(down_lvl_s), .rise(down_rise_s));
    settings_btn_edge u_centre (.clk(clk), .rst_n(rst_n), .btn(btn_centre),
                                .level(centre_lvl_s), .rise(centre_rise_s));

`ifdef SETTINGS_BLINK_EN
    logic [BLINK_BITS-1:0] blink_cnt_r;

    // Free-running blink timer; its MSB gates the highlight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= {BLINK_BITS{1'b0}};
        end else begin
            blink_cnt_r <= blink_cnt_r + {{(BLINK_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign hl_en_s = blink_cnt_r[BLINK_BITS-1];
`else
    assign hl_en_s = 1'b1;
`endif

    // Menu FSM: cursor moves in BROWSE; releasing centre in CONFIRM commits the mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_BROWSE;
            cursor_r     <= 1'b0;
            mode_r       <= MODE_NONE;
            mode_valid_r <= 1'b0;
        end else begin
            mode_valid_r <= 1'b0;
            case (state_r)
                ST_BROWSE: begin
                    if (centre_rise_s) begin
                        state_r <= ST_CONFIRM;
                    end else if (up_rise_s && !down_rise_s) begin
                        cursor_r <= 1'b0;
                    end else if (down_rise_s && !up_rise_s) begin
                        cursor_r <= 1'b1;
                    end else begin
                        cursor_r <= cursor_r;
                    end
                end
                ST_CONFIRM: begin
                    if (!centre_lvl_s) begin
                        mode_r       <= {1'b0, cursor_r} + 2'd1;
                        mode_valid_r <= 1'b1;
                        state_r      <= ST_BROWSE;
                    end else begin
                        state_r <= ST_CONFIRM;
                    end
                end
                default: state_r <= ST_BROWSE;
            endcase
        end
    end

    // Stage 1 address decode; out-of-range indices are flagged rather than clamped.
    always_comb begin
        x_s   = 7'(pix.pixel_index % 13'(WIDTH));
        y_s   = 6'(pix.pixel_index / 13'(WIDTH));
        oob_s = (pix.pixel_index >= 13'(WIDTH * HEIGHT));
    end

    // Stage 2 colour select: blanking beats highlight beats marker.
    always_comb begin
        pix_s = pix.settings_data;
        if (oob_r) begin
            pix_s = BLACK;
        end else if (hl_en_s && in_band(x_r, y_r, cursor_r)) begin
            pix_s = ~pix.settings_data;
        end else if (in_marker(x_r, y_r, mode_r)) begin
            pix_s = GREEN;
        end else begin
            pix_s = pix.settings_data;
        end
    end

    // Pixel pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= 7'd0;
            y_r    <= 6'd0;
            oob_r  <= 1'b0;
            oled_r <= 16'h0000;
        end else begin
            x_r    <= x_s;
            y_r    <= y_s;
            oob_r  <= oob_s;
            oled_r <= pix_s;
        end
    end

    assign pix.x         = x_r;
    assign pix.y         = y_r;
    assign pix.oled_data = oled_r;
    assign cursor        = cursor_r;
    assign mode          = mode_r;
    assign mode_valid    = mode_valid_r;

    // Up/down levels are only consumed as edges.
    logic unused_s;
    assign unused_s = up_lvl_s ^ down_lvl_s;
endmodule

// File: tb/tb_settings_menu_ctrl.sv
// Directed self-checking bench for settings_menu_ctrl.
module tb_settings_menu_ctrl;
    import settings_pkg::*;

    logic clk;
    logic rst_n;
    logic btn_up, btn_down, btn_centre;
    logic cursor;
    logic [1:0] mode;
    logic mode_valid;
    int n_tests;
    int n_fail;
    int pulses;
    logic hl;

    settings_menu_ctrl_if pif ();

    settings_menu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_centre(btn_centre),
        .pix(pif),
        .cursor(cursor), .mode(mode), .mode_valid(mode_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold the selected buttons high long enough to be seen, then release them.
    task automatic press(input logic u, input logic d);
        btn_up = u;
        btn_down = d;
        ticks(4);
        btn_up = 1'b0;
        btn_down = 1'b0;
        ticks(4);
    endtask

    task automatic pix_chk(input string tag, input logic [12:0] idx, input logic [15:0] sd,
                           input logic [6:0] ex, input logic [5:0] ey, input logic [15:0] eo);
        pif.pixel_index   = idx;
        pif.settings_data = sd;
        tick();
        check({tag, "_x"}, 32'(pif.x), 32'(ex));
        check({tag, "_y"}, 32'(pif.y), 32'(ey));
        tick();
        check({tag, "_oled"}, 32'(pif.oled_data), 32'(eo));
    endtask

    task automatic count_pulses(input int n);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (mode_valid) pulses++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
`ifdef SETTINGS_BLINK_EN
        hl = 1'b0;
`else
        hl = 1'b1;
`endif
        rst_n = 1'b0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_centre = 1'b0;
        pif.pixel_index = 13'd0;
        pif.settings_data = 16'h0000;
        #2;
        check("rst_x", 32'(pif.x), 32'd0);
        check("rst_y", 32'(pif.y), 32'd0);
        check("rst_oled", 32'(pif.oled_data), 32'h0);
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_mv", 32'(mode_valid), 32'd0);
        ticks(3);
        rst_n = 1'b1;
        ticks(2);

        // Pixel path, cursor 0, no mode committed.
        pix_chk("p3458", 13'd3458, WHITE, 7'd2, 6'd36, 16'hFFFF);
        pix_chk("band1", 13'd3486, WHITE, 7'd30, 6'd36, hl ? 16'h0000 : 16'hFFFF);
        pix_chk("band1b", 13'd3486, 16'h1234, 7'd30, 6'd36, hl ? 16'hEDCB : 16'h1234);
        pix_chk("oob", 13'd6144, 16'hABCD, 7'd0, 6'd0, 16'h0000);
        pix_chk("last", 13'd6143, 16'hABCD, 7'd95, 6'd63, 16'hABCD);
        pix_chk("nomark", 13'd4433, WHITE, 7'd17, 6'd46, 16'hFFFF);

        // Back-to-back indices.
        pif.settings_data = 16'h5A5A;
        pif.pixel_index = 13'd96;
        tick();
        pif.pixel_index = 13'd6200;
        tick();
        check("pipe_oled_a", 32'(pif.oled_data), 32'h5A5A);
        check("pipe_y_b", 32'(pif.y), 32'(6'(6200 / 96)));
        tick();
        check("pipe_oled_b", 32'(pif.oled_data), 32'h0000);

        // Cursor saturation and simultaneous edges.
        press(1'b0, 1'b1);
        check("down1", 32'(cursor), 32'd1);
        press(1'b0, 1'b1);
        check("down2", 32'(cursor), 32'd1);
        press(1'b1, 1'b1);
        check("updown", 32'(cursor), 32'd1);
        pix_chk("band2", 13'd4148, 16'h00FF, 7'd20, 6'd43, hl ? 16'hFF00 : 16'h00FF);
        pix_chk("band1off", 13'd3909, 16'h00FF, 7'd69, 6'd40, 16'h00FF);

        // Commit mode 2; a down press while confirming is ignored.
        btn_centre = 1'b1;
        ticks(4);
        press(1'b0, 1'b1);
        check("confirm_cursor", 32'(cursor), 32'd1);
        check("confirm_mode", 32'(mode), 32'd0);
        btn_centre = 1'b0;
        count_pulses(8);
        check("commit_pulses", 32'(pulses), 32'd1);
        check("commit_mode", 32'(mode), 32'd2);
        pix_chk("marker2", 13'd4433, WHITE, 7'd17, 6'd46, GREEN);
        pix_chk("mark1off", 13'd3472, WHITE, 7'd16, 6'd36, 16'hFFFF);

        // Reset mid-CONFIRM must clear asynchronously and never commit.
        btn_centre = 1'b1;
        ticks(4);
        rst_n = 1'b0;
        #1;
        check("arst_x", 32'(pif.x), 32'd0);
        check("arst_y", 32'(pif.y), 32'd0);
        check("arst_oled", 32'(pif.oled_data), 32'h0);
        check("arst_mode", 32'(mode), 32'd0);
        check("arst_cursor", 32'(cursor), 32'd0);
        btn_centre = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        count_pulses(8);
        check("arst_pulses", 32'(pulses), 32'd0);
        check("arst_mode2", 32'(mode), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
